// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter family: run-time mode codes and
// the one-shot sequencer states. Imported by updown_counter and count_prescaler.
package counter_pkg;

    // Run-time counting mode; code 3 is reserved and decodes as wrap.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    // One-shot sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : counter_pkg

// File: rtl/count_prescaler.sv
// Enable divider for updown_counter: tick is high on the enabled cycle that
// completes each group of PRESCALE enabled cycles. Only instantiated when
// UPDOWN_COUNTER_PRESCALE_EN is defined.
module count_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST_L = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ONE_L  = CW'(1);
    localparam logic [CW-1:0] ZERO_L = CW'(0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The last position of a group, seen with en, is the advancing cycle.
    assign tick = en & (cnt_q == LAST_L);

    // Next group position: clear wins, otherwise step on en and fold at the end.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = ZERO_L;
        end else if (en) begin
            if (tick) begin
                cnt_d = ZERO_L;
            end else begin
                cnt_d = cnt_q + ONE_L;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Group position register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= ZERO_L;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : count_prescaler

// File: rtl/updown_counter.sv
// Bounded up/down counter with parallel load and wrap / saturate / one-shot
// modes. Count range is [MIN_VALUE, MAX_VALUE]; out never leaves it because
// loads are clamped. tc is combinational so it can feed the en of a cascaded
// stage. Optional enable prescaler: define UPDOWN_COUNTER_PRESCALE_EN.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MIN_VALUE = 0,
    parameter int MAX_VALUE = 255
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE  = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    output logic             tick,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MIN_L = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] ONE_L = WIDTH'(1);

    // Force a load value into the legal count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v < MIN_L) begin
            r = MIN_L;
        end else if (v > MAX_L) begin
            r = MAX_L;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [WIDTH-1:0] out_q, out_d;
    state_e           state_q, state_d;
    logic             busy_q, done_q;

    logic [WIDTH-1:0] term_s;    // bound reached in the current direction
    logic [WIDTH-1:0] origin_s;  // opposite bound: wrap target and one-shot start value
    logic [WIDTH-1:0] step_s;    // one count in the current direction
    logic             at_term_s;
    logic             held_s;    // one-shot that is not running
    logic             tick_s;
    logic             adv_s;
    mode_e            mode_s;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    count_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (load),
        .en   (en),
        .tick (tick_s)
    );
    assign tick = tick_s;
`else
    assign tick_s = 1'b1;
`endif

    assign mode_s    = mode_e'(mode);
    assign term_s    = up ? MAX_L : MIN_L;
    assign origin_s  = up ? MIN_L : MAX_L;
    assign step_s    = up ? (out_q + ONE_L) : (out_q - ONE_L);
    assign at_term_s = (out_q == term_s);
    assign held_s    = (mode_s == MODE_ONESHOT) & (state_q != ST_RUN);
    assign adv_s     = en & tick_s;

    assign tc   = en & tick_s & at_term_s & ~held_s;
    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

    // Next count and one-shot state; priority is load > start > en.
    always_comb begin
        out_d   = out_q;
        state_d = state_q;
        case (mode_s)
            MODE_ONESHOT: begin
                if (load) begin
                    out_d = clamp_load(load_value);
                end else if (start) begin
                    out_d   = origin_s;
                    state_d = ST_RUN;
                end else if ((state_q == ST_RUN) && adv_s) begin
                    if (at_term_s) begin
                        state_d = ST_DONE;
                    end else begin
                        out_d = step_s;
                    end
                end else begin
                    out_d = out_q;
                end
            end
            default: begin
                // Wrap, saturate and the reserved code; one-shot sequencer parks.
                state_d = ST_IDLE;
                if (load) begin
                    out_d = clamp_load(load_value);
                end else if (adv_s) begin
                    if (!at_term_s) begin
                        out_d = step_s;
                    end else if (mode_s == MODE_SAT) begin
                        out_d = out_q;
                    end else begin
                        out_d = origin_s;
                    end
                end else begin
                    out_d = out_q;
                end
            end
        endcase
    end

    // State and registered status flags; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= MIN_L;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            state_q <= state_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter (WIDTH=4, range 2..9): directed
// steps from the test plan followed by randomized traffic, all compared
// against a behavioural model of the counter's rules.
module tb_updown_counter;

    localparam int W    = 4;
    localparam int MINV = 2;
    localparam int MAXV = 9;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int P = 3;
`else
    localparam int P = 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = 4'd0;
    logic         start = 1'b0;
    logic [W-1:0] out;
    logic         tc;
    logic         busy;
    logic         done;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    logic         tick;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: count value, one-shot phase, prescaler position.
    int    m_out   = MINV;
    string m_phase = "idle";
    int    m_pre   = 0;

    always #5 clk = ~clk;

    updown_counter #(
        .WIDTH    (W),
        .MIN_VALUE(MINV),
        .MAX_VALUE(MAXV)
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        ,
        .PRESCALE (P)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up        (up),
        .mode      (mode),
        .load      (load),
        .load_value(load_value),
        .start     (start),
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        .tick      (tick),
`endif
        .out       (out),
        .tc        (tc),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Apply one cycle of inputs, check tc before the edge and registered outputs after it.
    task automatic step(input bit r, input bit e, input bit u, input int md,
                        input bit ld, input int lv, input bit st);
        bit oneshot, ptick, adv, held, exp_tc;
        int term, origin;
        reset = r; en = e; up = u; mode = md[1:0]; load = ld;
        load_value = lv[W-1:0]; start = st;
        #1;
        oneshot = (md == 2);
        term    = u ? MAXV : MINV;
        origin  = u ? MINV : MAXV;
        ptick   = e && (m_pre == P - 1);
        adv     = e && ptick;
        held    = oneshot && (m_phase != "run");
        exp_tc  = e && ptick && (m_out == term) && !held;
        check("tc", int'(tc), int'(exp_tc));
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        check("tick", int'(tick), int'(ptick));
`endif
        @(posedge clk);
        if (r) begin
            m_out = MINV; m_phase = "idle"; m_pre = 0;
        end else begin
            if (ld) m_pre = 0;
            else if (e) m_pre = ptick ? 0 : m_pre + 1;
            if (!oneshot) begin
                m_phase = "idle";
                if (ld) m_out = (lv < MINV) ? MINV : ((lv > MAXV) ? MAXV : lv);
                else if (adv) begin
                    if (m_out != term) m_out = m_out + (u ? 1 : -1);
                    else if (md != 1) m_out = origin;
                end
            end else begin
                if (ld) m_out = (lv < MINV) ? MINV : ((lv > MAXV) ? MAXV : lv);
                else if (st) begin
                    m_out = origin; m_phase = "run";
                end else if (m_phase == "run" && adv) begin
                    if (m_out == term) m_phase = "done";
                    else m_out = m_out + (u ? 1 : -1);
                end
            end
        end
        #1;
        check("out", int'(out), m_out);
        check("busy", int'(busy), int'(m_phase == "run"));
        check("done", int'(done), int'(m_phase == "done"));
    endtask

    initial begin
        #2;
        // Reset state
        step(1, 0, 1, 0, 0, 0, 0);
        check("reset_out", int'(out), 2);
        check("reset_busy", int'(busy), 0);

        // Wrap, up, continuous enable: 2..9 then back to 2
        for (int i = 0; i < 10 * P; i++) step(0, 1, 1, 0, 0, 0, 0);

        // Saturate down from 3 holds at the lower bound with tc high
        step(0, 0, 0, 1, 1, 3, 0);
        check("load3", int'(out), 3);
        for (int i = 0; i < 4 * P; i++) step(0, 1, 0, 1, 0, 0, 0);
        check("sat_hold", int'(out), 2);

        // Load clamping and load beating en
        step(0, 0, 1, 0, 1, 15, 0);
        check("load_clamp_hi", int'(out), 9);
        step(0, 0, 1, 0, 1, 0, 0);
        check("load_clamp_lo", int'(out), 2);
        step(0, 1, 1, 0, 1, 7, 0);
        check("load_over_en", int'(out), 7);

        // One-shot run to completion, then re-arm
        step(0, 0, 1, 2, 0, 0, 1);
        check("os_start_out", int'(out), 2);
        check("os_start_busy", int'(busy), 1);
        for (int i = 0; i < 10 * P; i++) step(0, 1, 1, 2, 0, 0, 0);
        check("os_done", int'(done), 1);
        check("os_hold", int'(out), 9);
        step(0, 1, 1, 2, 0, 0, 1);
        check("os_rearm_out", int'(out), 2);
        check("os_rearm_done", int'(done), 0);

        // Reset mid-run while loading
        for (int i = 0; i < 2 * P; i++) step(0, 1, 1, 2, 0, 0, 0);
        step(1, 1, 1, 2, 1, 6, 0);
        check("rst_over_load", int'(out), 2);
        check("rst_busy", int'(busy), 0);

        // Finish a one-shot, then leave one-shot mode
        step(0, 0, 1, 2, 0, 0, 1);
        for (int i = 0; i < 10 * P; i++) step(0, 1, 1, 2, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        check("leave_os_done", int'(done), 0);

        // Randomized traffic, including the reserved mode and direction flips
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_updown_counter
